// File: rtl/ws_frame_sched.sv
// Frame scheduler for the ws2812 driver core: snapshots an LED on/off vector and emits one write per LED.
// Optional brightness scaling of the ON colour is enabled by defining WS_SCHED_BRIGHT_EN.
module ws_frame_sched #(
    parameter int          NUM_LEDS   = 24,
    parameter logic [23:0] ON_COLOR   = 24'h10_10_10,
    parameter logic [23:0] OFF_COLOR  = 24'h00_00_00,
    parameter int          GAP_CYCLES = 2
) (
    input  logic                hwclk,
    input  logic                reset,
    input  logic [NUM_LEDS-1:0] bits,
    input  logic                frame_req,
`ifdef WS_SCHED_BRIGHT_EN
    input  logic [2:0]          brightness,
`endif
    output logic                busy,
    output logic                done,
    output logic [7:0]          led_num,
    output logic [23:0]         rgb_data,
    output logic                write
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WRITE,
        S_GAP,
        S_DONE
    } state_t;

    localparam int          GW       = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [GW-1:0] GAP_LAST = (GAP_CYCLES > 0) ? GW'(GAP_CYCLES - 1) : '0;
    localparam logic [7:0]  IDX_LAST = 8'(NUM_LEDS - 1);

    state_t                state_q, state_d;
    logic [7:0]            idx_q, idx_d;
    logic [GW-1:0]         gap_q, gap_d;
    logic [NUM_LEDS-1:0]   shadow_q, shadow_d;
    logic                  pending_q, pending_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  write_q, write_d;
    logic [7:0]            led_q, led_d;
    logic [23:0]           rgb_q, rgb_d;
    logic                  frame_start;
    logic [23:0]           on_word;

    assign frame_start = (state_q == S_IDLE) && (frame_req || pending_q);

`ifdef WS_SCHED_BRIGHT_EN
    logic [2:0] bright_q, bright_d;

    assign bright_d = frame_start ? brightness : bright_q;

    // Each colour byte is attenuated independently so hue is roughly preserved.
    for (genvar gi = 0; gi < 3; gi++) begin : g_scale
        assign on_word[gi*8 +: 8] = ON_COLOR[gi*8 +: 8] >> bright_d;
    end

    always_ff @(posedge hwclk or negedge reset) begin
        if (!reset) begin
            bright_q <= '0;
        end else begin
            bright_q <= bright_d;
        end
    end
`else
    assign on_word = ON_COLOR;
`endif

    always_comb begin
        logic advance;
        logic sel_bit;
        state_d   = state_q;
        idx_d     = idx_q;
        gap_d     = gap_q;
        shadow_d  = shadow_q;
        pending_d = pending_q;
        led_d     = led_q;
        rgb_d     = rgb_q;
        advance   = 1'b0;
        sel_bit   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (frame_start) begin
                    shadow_d  = bits;
                    idx_d     = '0;
                    pending_d = 1'b0;
                    state_d   = S_WRITE;
                end
            end
            S_WRITE: begin
                gap_d = '0;
                if (GAP_CYCLES > 0) begin
                    state_d = S_GAP;
                end else begin
                    advance = 1'b1;
                end
            end
            S_GAP: begin
                if (gap_q == GAP_LAST) begin
                    advance = 1'b1;
                end else begin
                    gap_d = gap_q + 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (advance) begin
            if (idx_q == IDX_LAST) begin
                state_d = S_DONE;
            end else begin
                idx_d   = idx_q + 8'd1;
                state_d = S_WRITE;
            end
        end

        // Requests arriving while a frame is running coalesce into one follow-up frame.
        if ((state_q != S_IDLE) && frame_req) begin
            pending_d = 1'b1;
        end

        // Outputs are registered, so they are derived from the state being entered.
        write_d = (state_d == S_WRITE);
        busy_d  = (state_d != S_IDLE);
        done_d  = (state_d == S_DONE);

        for (int i = 0; i < NUM_LEDS; i++) begin
            if (idx_d == 8'(i)) begin
                sel_bit = shadow_d[i];
            end
        end

        if (write_d) begin
            led_d = idx_d;
            rgb_d = sel_bit ? on_word : OFF_COLOR;
        end
    end

    always_ff @(posedge hwclk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            idx_q     <= '0;
            gap_q     <= '0;
            shadow_q  <= '0;
            pending_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            write_q   <= 1'b0;
            led_q     <= '0;
            rgb_q     <= '0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            gap_q     <= gap_d;
            shadow_q  <= shadow_d;
            pending_q <= pending_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            write_q   <= write_d;
            led_q     <= led_d;
            rgb_q     <= rgb_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign write    = write_q;
    assign led_num  = led_q;
    assign rgb_data = rgb_q;

endmodule

// File: tb/tb_ws_frame_sched.sv
// Self-checking bench for ws_frame_sched (NUM_LEDS=4, GAP_CYCLES=2): directed table, corner sequences,
// and random requests checked against a schedule-based reference model.
module tb_ws_frame_sched;

    localparam int          N   = 4;
    localparam int          G   = 2;
    localparam int          P   = G + 1;
    localparam int          L   = N * P;
    localparam logic [23:0] ON  = 24'h10_10_10;
    localparam logic [23:0] OFF = 24'h00_00_00;

    logic         hwclk = 1'b0;
    logic         reset = 1'b0;
    logic         frame_req = 1'b0;
    logic [N-1:0] bits = '0;
    logic [2:0]   brightness = 3'd0;
    logic         busy, done, write;
    logic [7:0]   led_num;
    logic [23:0]  rgb_data;

    ws_frame_sched #(
        .NUM_LEDS  (N),
        .ON_COLOR  (ON),
        .OFF_COLOR (OFF),
        .GAP_CYCLES(G)
    ) dut (
        .hwclk    (hwclk),
        .reset    (reset),
        .bits     (bits),
        .frame_req(frame_req),
`ifdef WS_SCHED_BRIGHT_EN
        .brightness(brightness),
`endif
        .busy     (busy),
        .done     (done),
        .led_num  (led_num),
        .rgb_data (rgb_data),
        .write    (write)
    );

    always #5 hwclk = ~hwclk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: a frame is a schedule anchored at its first-write cycle.
    int           m_cyc, m_start;
    bit           m_active, m_pend;
    logic [N-1:0] m_snap;
    logic [2:0]   m_bright;
    logic [7:0]   m_led;
    logic [23:0]  m_rgb;

    function automatic logic [23:0] on_word(input logic [2:0] b);
        logic [23:0] c;
        c = ON;
        return {c[23:16] >> b, c[15:8] >> b, c[7:0] >> b};
    endfunction

    task automatic model_reset();
        m_cyc = 0; m_start = 0; m_active = 0; m_pend = 0;
        m_snap = '0; m_bright = '0; m_led = '0; m_rgb = '0;
    endtask

    task automatic cycle(input logic req, input logic [N-1:0] b,
                         output logic o_w, output logic [7:0] o_l, output logic [23:0] o_r,
                         output logic o_b, output logic o_d);
        int t;
        logic e_w, e_b, e_d;
        frame_req = req;
        bits      = b;
        @(negedge hwclk);
        o_w = write; o_l = led_num; o_r = rgb_data; o_b = busy; o_d = done;
        t   = m_cyc - m_start;
        e_b = m_active && (t >= 0) && (t <= L);
        e_w = m_active && (t >= 0) && (t < L) && ((t % P) == 0);
        e_d = m_active && (t == L);
        if (e_w) begin
            m_led = 8'(t / P);
            m_rgb = m_snap[t / P] ? on_word(m_bright) : OFF;
        end
        chk("model_write", 32'(o_w), 32'(e_w));
        chk("model_busy",  32'(o_b), 32'(e_b));
        chk("model_done",  32'(o_d), 32'(e_d));
        chk("model_led",   32'(o_l), 32'(m_led));
        chk("model_rgb",   32'(o_r), 32'(m_rgb));
        if (!e_b) begin
            if (req || m_pend) begin
                m_active = 1; m_start = m_cyc + 1; m_snap = b; m_bright = brightness; m_pend = 0;
            end
        end else if (req) begin
            m_pend = 1;
        end
        m_cyc++;
        @(posedge hwclk);
        #1;
    endtask

    typedef struct {
        logic         req;
        logic [N-1:0] bits;
        logic         w;
        logic [7:0]   led;
        logic [23:0]  rgb;
        logic         busy;
        logic         done;
    } vec_t;

    vec_t tbl[15];

    task automatic set_row(input int i, input logic r, input logic [N-1:0] b, input logic w,
                           input logic [7:0] l, input logic [23:0] c, input logic bz, input logic d);
        tbl[i].req = r; tbl[i].bits = b; tbl[i].w = w; tbl[i].led = l;
        tbl[i].rgb = c; tbl[i].busy = bz; tbl[i].done = d;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic        ow, ob, od;
        logic [7:0]  ol;
        logic [23:0] orr;
        int          dcnt, d1, w2, k;
        bit          found;

        set_row( 0, 1'b1, 4'b1010, 1'b0, 8'd0, 24'h000000, 1'b0, 1'b0);
        set_row( 1, 1'b0, 4'b1010, 1'b1, 8'd0, 24'h000000, 1'b1, 1'b0);
        set_row( 2, 1'b0, 4'b0101, 1'b0, 8'd0, 24'h000000, 1'b1, 1'b0);
        set_row( 3, 1'b0, 4'b0101, 1'b0, 8'd0, 24'h000000, 1'b1, 1'b0);
        set_row( 4, 1'b0, 4'b0101, 1'b1, 8'd1, 24'h101010, 1'b1, 1'b0);
        set_row( 5, 1'b0, 4'b0101, 1'b0, 8'd1, 24'h101010, 1'b1, 1'b0);
        set_row( 6, 1'b0, 4'b0101, 1'b0, 8'd1, 24'h101010, 1'b1, 1'b0);
        set_row( 7, 1'b0, 4'b0101, 1'b1, 8'd2, 24'h000000, 1'b1, 1'b0);
        set_row( 8, 1'b0, 4'b0101, 1'b0, 8'd2, 24'h000000, 1'b1, 1'b0);
        set_row( 9, 1'b0, 4'b0101, 1'b0, 8'd2, 24'h000000, 1'b1, 1'b0);
        set_row(10, 1'b0, 4'b0101, 1'b1, 8'd3, 24'h101010, 1'b1, 1'b0);
        set_row(11, 1'b0, 4'b0101, 1'b0, 8'd3, 24'h101010, 1'b1, 1'b0);
        set_row(12, 1'b0, 4'b0101, 1'b0, 8'd3, 24'h101010, 1'b1, 1'b0);
        set_row(13, 1'b0, 4'b0101, 1'b0, 8'd3, 24'h101010, 1'b1, 1'b1);
        set_row(14, 1'b0, 4'b0101, 1'b0, 8'd3, 24'h101010, 1'b0, 1'b0);

        model_reset();
        repeat (3) @(posedge hwclk);
        #1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_rgb",  32'(rgb_data), 32'd0);
        reset = 1'b1;

        // Idle after reset release: everything must stay quiet.
        for (int i = 0; i < 20; i++) begin
            cycle(1'b0, 4'b0000, ow, ol, orr, ob, od);
            chk("idle_write", 32'(ow), 32'd0);
            chk("idle_led",   32'(ol), 32'd0);
        end

        // Directed frame with a mid-frame change of bits (tear-free).
        for (int i = 0; i < 15; i++) begin
            cycle(tbl[i].req, tbl[i].bits, ow, ol, orr, ob, od);
            chk($sformatf("tbl%0d_write", i), 32'(ow),  32'(tbl[i].w));
            chk($sformatf("tbl%0d_led", i),   32'(ol),  32'(tbl[i].led));
            chk($sformatf("tbl%0d_rgb", i),   32'(orr), 32'(tbl[i].rgb));
            chk($sformatf("tbl%0d_busy", i),  32'(ob),  32'(tbl[i].busy));
            chk($sformatf("tbl%0d_done", i),  32'(od),  32'(tbl[i].done));
        end

        // Next frame picks up the new snapshot 0101: LED0 is on.
        cycle(1'b1, 4'b0101, ow, ol, orr, ob, od);
        cycle(1'b0, 4'b0000, ow, ol, orr, ob, od);
        chk("snap2_write", 32'(ow),  32'd1);
        chk("snap2_rgb0",  32'(orr), 32'h101010);
        repeat (16) cycle(1'b0, 4'b0000, ow, ol, orr, ob, od);

        // Coalescing: three requests during one frame yield exactly one more frame.
        dcnt = 0; d1 = -1; w2 = -1;
        for (int i = 0; i < 40; i++) begin
            cycle((i == 0) || (i == 3) || (i == 6) || (i == 9), 4'b0110, ow, ol, orr, ob, od);
            if (od) begin
                dcnt++;
                if (d1 < 0) d1 = i;
            end
            if (ow && (d1 >= 0) && (w2 < 0)) w2 = i;
        end
        chk("coal_done_count", 32'(dcnt), 32'd2);
        chk("coal_restart_gap", 32'(w2 - d1), 32'd2);

        // Abort: reset mid-frame at LED 2, with a pending request that must be lost.
        cycle(1'b1, 4'b1111, ow, ol, orr, ob, od);
        found = 0;
        k = 0;
        while (!found && (k < 50)) begin
            cycle(k == 1, 4'b1111, ow, ol, orr, ob, od);
            if (ow && (ol == 8'd2)) found = 1;
            k++;
        end
        chk("abort_reached_led2", 32'(found), 32'd1);
        #2 reset = 1'b0;
        #1;
        chk("abort_led",   32'(led_num),  32'd0);
        chk("abort_rgb",   32'(rgb_data), 32'd0);
        chk("abort_busy",  32'(busy),     32'd0);
        chk("abort_write", 32'(write),    32'd0);
        chk("abort_done",  32'(done),     32'd0);
        model_reset();
        @(posedge hwclk);
        @(posedge hwclk);
        #1 reset = 1'b1;
        repeat (20) cycle(1'b0, 4'b1111, ow, ol, orr, ob, od);
        cycle(1'b1, 4'b0001, ow, ol, orr, ob, od);
        cycle(1'b0, 4'b0000, ow, ol, orr, ob, od);
        chk("restart_write", 32'(ow), 32'd1);
        chk("restart_led",   32'(ol), 32'd0);
        repeat (15) cycle(1'b0, 4'b0000, ow, ol, orr, ob, od);

`ifdef WS_SCHED_BRIGHT_EN
        brightness = 3'd3;
        cycle(1'b1, 4'b1111, ow, ol, orr, ob, od);
        for (int i = 0; i < 14; i++) begin
            cycle(1'b0, 4'b1111, ow, ol, orr, ob, od);
            if (ow) chk("bright3_rgb", 32'(orr), 32'h020202);
        end
        brightness = 3'd0;
        cycle(1'b1, 4'b1111, ow, ol, orr, ob, od);
        for (int i = 0; i < 14; i++) begin
            cycle(1'b0, 4'b1111, ow, ol, orr, ob, od);
            if (ow) chk("bright0_rgb", 32'(orr), 32'h101010);
        end
`endif

        // Random requests and bit patterns, checked only by the reference model.
        for (int i = 0; i < 300; i++) begin
`ifdef WS_SCHED_BRIGHT_EN
            brightness = 3'($urandom_range(0, 7));
`endif
            cycle($urandom_range(0, 7) == 0, 4'($urandom), ow, ol, orr, ob, od);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/ws_frame_sched.md
Name: ws_frame_sched

Overview:
- Frame scheduler for the ws2812 LED driver core.
- On each refresh request it snapshots a packed LED on/off vector (e.g. the BCD clock digits) and walks LED indices 0..NUM_LEDS-1.
- For each LED it presents led_num/rgb_data with a single-cycle write strobe.
- Replaces ad-hoc led_num loops in the top level with a sequenced, tear-free, coalescing refresh controller.

Parameters:
- NUM_LEDS, 24: LEDs per frame; bit i of bits drives LED i. Range 1..256.
- ON_COLOR, 24'h10_10_10: GRB/RGB word sent for a set bit.
- OFF_COLOR, 24'h00_00_00: word sent for a clear bit.
- GAP_CYCLES, 2: idle cycles after each write strobe; 0 allowed.

Ports:
- hwclk  input  1  system clock (12 MHz).
- reset  input  1  asynchronous, active-low reset.
- bits  input  NUM_LEDS  LED on/off vector; sampled only at frame start.
- frame_req  input  1  refresh request, level-sampled each cycle.
- busy  output  1  frame in progress.
- done  output  1  one-cycle pulse at frame end.
- led_num  output  8  LED index to driver core.
- rgb_data  output  24  colour word to driver core.
- write  output  1  write strobe to driver core.
- brightness  input  3  right-shift applied to ON_COLOR bytes (present only with WS_SCHED_BRIGHT_EN).

Behaviour:
- Reset (reset low, asynchronous):
  - state=IDLE; led_num=0, rgb_data=0, write=0, busy=0, done=0; pending=0, idx=0, gap counter=0.
  - Asserting reset mid-frame aborts immediately; no done pulse; pending is lost.
- All outputs are registered.
- IDLE:
  - On an edge with frame_req=1 or pending=1: capture shadow<=bits, idx<=0, pending<=0, busy<=1, go to WRITE.
  - led_num and rgb_data hold their last values while in IDLE.
- WRITE (exactly 1 cycle):
  - write=1, led_num=idx, rgb_data=shadow[idx] ? ON_COLOR : OFF_COLOR.
  - The write strobe appears on the cycle after frame_req is sampled (latency 1).
  - Next state: GAP if GAP_CYCLES>0; else NEXT logic directly.
- GAP:
  - write=0; stay for GAP_CYCLES cycles.
  - Then: if idx==NUM_LEDS-1 go to DONE; else idx<=idx+1 and go to WRITE.
- DONE (1 cycle):
  - done=1, busy still 1, write=0.
  - Next: IDLE with busy=0, done=0.
- Frame length from the first write to done, inclusive: NUM_LEDS*(1+GAP_CYCLES)+1 cycles.
  - If GAP_CYCLES=0, consecutive WRITE cycles are back-to-back.
- Request handling and boundaries:
  - Tear-free: changes on bits during a frame are ignored until the next frame snapshot.
  - frame_req=1 in any non-IDLE state sets pending. Multiple requests coalesce into one.
  - A pending request starts the next frame one cycle after DONE (IDLE occupies exactly 1 cycle).
  - frame_req held high continuously gives back-to-back frames separated by one IDLE cycle.
  - frame_req in the same cycle as DONE also sets pending.
  - NUM_LEDS=1: a single WRITE, then GAP, then DONE.
  - idx never exceeds NUM_LEDS-1. led_num is zero-extended idx.

Optional Feature:
- WS_SCHED_BRIGHT_EN defined:
  - brightness port exists and is sampled into a shadow register at frame start.
  - The ON word is ON_COLOR with each byte independently logically shifted right by the brightness value (0..7).
  - Shifts 0..7 on an 8-bit byte give 0 or a smaller value; 7 reduces 0x10 to 0.
  - OFF_COLOR is unscaled.
- WS_SCHED_BRIGHT_EN undefined:
  - brightness port is absent.
  - ON_COLOR is sent unmodified.
  - No extra registers.

Test Plan:
- Reset release, then idle 20 cycles with frame_req=0 -> write=0, busy=0, done=0, led_num=0, rgb_data=0 throughout.
- NUM_LEDS=4, GAP_CYCLES=2, bits=4'b1010, one-cycle frame_req:
  - writes at cycles +1, +4, +7, +10 with led_num 0,1,2,3.
  - rgb_data 000000, 101010, 000000, 101010.
  - done pulse at +13; busy low from +14.
- Tear-free check: during the frame above, change bits to 4'b0101 after the first write -> the remaining writes still use 1010. The next frame uses 0101.
- Coalescing: frame_req pulsed 3 times during a busy frame -> exactly one extra frame; its first write occurs 2 cycles after the done pulse; two done pulses in total.
- Abort: reset pulsed low mid-frame at led_num=2 -> all outputs 0 asynchronously, no done. After release, a new frame_req restarts at led_num=0.
- WS_SCHED_BRIGHT_EN, brightness=3, bits=4'b1111 -> every rgb_data=24'h02_02_02. With brightness=0 -> 24'h10_10_10.
